// File: rtl/rcpu_io_uart.sv
// Memory-mapped LED register plus a FIFO-buffered 8N1 UART transmitter.
// IO buses are [0:15]; internally they are remapped to [15:0] so bit n has weight 2**n.
module rcpu_io_uart #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        io_read_enable,
   input  logic        io_write_enable,
   input  logic [0:15] io_address,
   input  logic [0:15] io_write_data,
   output logic [0:15] io_read_data,
   output logic [7:0]  leds,
   output logic        uart_tx
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [15:0] A_LED  = 16'h0000;
   localparam logic [15:0] A_TX   = 16'h0001;
   localparam logic [15:0] A_STAT = 16'h0002;

   logic [15:0] addr;
   logic [15:0] wdata;
   logic        unused_wdata;

   logic [1:0]                  state_q, state_d;
   logic [BW-1:0]               baud_q, baud_d;
   logic [2:0]                  bit_q, bit_d;
   logic [7:0]                  shift_q, shift_d;
   logic                        tx_q, tx_d;
   logic [7:0]                  leds_q, leds_d;
   logic                        ovf_q, ovf_d;
   logic [15:0]                 rdata_q, rdata_d;
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic [FIFO_DEPTH-1:0][7:0]  fifo_q, fifo_d;

   logic        full, empty, busy, pop, push_req, push_ok, stat_clr;
   logic [15:0] status;

   assign addr         = io_address;
   assign wdata        = io_write_data;
   assign unused_wdata = ^wdata[15:8];

   assign io_read_data = rdata_q;
   assign leds         = leds_q;
   assign uart_tx      = tx_q;

   always_comb begin
      full     = (count_q == CNT_FULL);
      empty    = (count_q == '0);
      busy     = (state_q != S_IDLE);
      pop      = (state_q == S_IDLE) && !empty;
      push_req = io_write_enable && (addr == A_TX);
      // a full FIFO still takes the byte when the transmitter frees a slot this cycle
      push_ok  = push_req && (!full || pop);
      stat_clr = io_write_enable && (addr == A_STAT) && wdata[3];
      status   = {8'(count_q), 4'h0, ovf_q, busy, empty, full};

      rdata_d = rdata_q;
      if (io_read_enable) begin
         case (addr)
            A_LED:   rdata_d = {8'h00, leds_q};
            A_STAT:  rdata_d = status;
            default: rdata_d = '0;
         endcase
      end

      leds_d = leds_q;
      if (io_write_enable && (addr == A_LED)) leds_d = wdata[7:0];

      ovf_d = (push_req && !push_ok) || (ovf_q && !stat_clr);

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         fifo_d[wr_ptr_q] = wdata[7:0];
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push_ok && !pop) count_d = count_q + 1'b1;
      else if (pop && !push_ok) count_d = count_q - 1'b1;

      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               shift_d = fifo_q[rd_ptr_q];
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else bit_d = bit_q + 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
      endcase

      // line level is derived from the next state so uart_tx lines up with state_q
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         leds_q   <= '0;
         ovf_q    <= 1'b0;
         rdata_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         fifo_q   <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         leds_q   <= leds_d;
         ovf_q    <= ovf_d;
         rdata_q  <= rdata_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         fifo_q   <= fifo_d;
      end
   end

endmodule

// File: tb/tb_rcpu_io_uart.sv
// Self-checking bench for rcpu_io_uart: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rcpu_io_uart;

   localparam int C = 4;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        resetq = 1'b0;
   logic        re = 1'b0;
   logic        we = 1'b0;
   logic [0:15] addr = '0;
   logic [0:15] wd = '0;
   logic [0:15] rd;
   logic [7:0]  leds;
   logic        tx;

   int checks = 0;
   int errors = 0;

   rcpu_io_uart #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clk             (clk),
      .resetq          (resetq),
      .io_read_enable  (re),
      .io_write_enable (we),
      .io_address      (addr),
      .io_write_data   (wd),
      .io_read_data    (rd),
      .leds            (leds),
      .uart_tx         (tx)
   );

   always #5 clk = ~clk;

   // Reference model: FIFO as a queue, transmitter as a frame position counter.
   logic [7:0]  m_q[$];
   logic [7:0]  m_leds, m_byte;
   logic        m_ov, m_busy, m_pop, m_set, m_clr;
   logic [15:0] m_rd, m_a, m_d;
   int          m_phase, m_sz;

   task automatic m_reset();
      m_q.delete();
      m_leds  = '0;
      m_byte  = '0;
      m_ov    = 1'b0;
      m_rd    = '0;
      m_phase = -1;
   endtask

   initial m_reset();
   always @(negedge resetq) m_reset();

   always @(posedge clk) begin
      if (resetq) begin
         m_a    = addr;
         m_d    = wd;
         m_sz   = m_q.size();
         m_busy = (m_phase >= 0);
         m_pop  = !m_busy && (m_sz > 0);
         m_set  = 1'b0;
         m_clr  = 1'b0;
         if (re) begin
            if (m_a == 16'h0000) m_rd = {8'h00, m_leds};
            else if (m_a == 16'h0002)
               m_rd = {8'(m_sz), 4'h0, m_ov, m_busy, (m_sz == 0), (m_sz == D)};
            else m_rd = 16'h0000;
         end
         if (m_pop) begin
            m_byte  = m_q.pop_front();
            m_phase = 0;
         end else if (m_phase >= 0) begin
            m_phase = m_phase + 1;
            if (m_phase == 10 * C) m_phase = -1;
         end
         if (we) begin
            if (m_a == 16'h0000) m_leds = m_d[7:0];
            if (m_a == 16'h0001) begin
               if (m_sz < D || m_pop) m_q.push_back(m_d[7:0]);
               else m_set = 1'b1;
            end
            if (m_a == 16'h0002 && m_d[3]) m_clr = 1'b1;
         end
         m_ov = m_set || (m_ov && !m_clr);
      end
   end

   function automatic logic exp_tx();
      if (m_phase < 0) return 1'b1;
      if (m_phase < C) return 1'b0;
      if (m_phase < 9 * C) return m_byte[(m_phase - C) / C];
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (resetq) begin
         check("uart_tx", {15'b0, tx}, {15'b0, exp_tx()});
         check("leds", {8'h00, leds}, {8'h00, m_leds});
         check("io_read_data", rd, m_rd);
      end
   end

   task automatic op(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
      we   = w;
      re   = r;
      addr = a;
      wd   = d;
      @(negedge clk);
      we = 1'b0;
      re = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((m_phase >= 0 || m_q.size() != 0) && n < 2000) begin
         op(1'b0, 1'b0, 16'h0, 16'h0);
         n++;
      end
      check("drain_timeout", 16'(n >= 2000), 16'h0);
      op(1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   logic [9:0]  fr;
   logic        s[40];
   logic [15:0] st;
   logic        prev;
   int          falls[$];
   int          n, bad;

   initial begin
      fr = 10'b1010101010;

      repeat (3) @(negedge clk);
      check("reset_tx", {15'b0, tx}, 16'h0001);
      check("reset_leds", {8'h00, leds}, 16'h0000);
      check("reset_rd", rd, 16'h0000);

      // first access right after release
      resetq = 1'b1;
      op(1'b1, 1'b0, 16'h0000, 16'h00A5);
      check("led_write", {8'h00, leds}, 16'h00A5);
      op(1'b0, 1'b1, 16'h0000, 16'h0000);
      check("led_read", rd, 16'h00A5);

      op(1'b1, 1'b0, 16'h1234, 16'h1234);
      op(1'b0, 1'b1, 16'h1234, 16'h0000);
      check("unmapped_read", rd, 16'h0000);
      op(1'b0, 1'b1, 16'h0000, 16'h0000);
      check("led_after_unmapped", rd, 16'h00A5);
      op(1'b0, 1'b1, 16'h0001, 16'h0000);
      check("txdata_read", rd, 16'h0000);
      op(1'b0, 1'b1, 16'h0002, 16'h0000);
      check("status_idle", rd, 16'h0002);

      op(1'b1, 1'b1, 16'h0000, 16'h003C);
      check("rw_same_cycle_read", rd, 16'h00A5);
      check("rw_same_cycle_leds", {8'h00, leds}, 16'h003C);

      // single 0x55 frame
      op(1'b1, 1'b0, 16'h0001, 16'h0055);
      n = 0;
      while (tx !== 1'b0 && n < 8) begin
         op(1'b0, 1'b0, 16'h0, 16'h0);
         n++;
      end
      check("start_timeout", 16'(n >= 8), 16'h0);
      s[0] = tx;
      st = '0;
      for (int i = 1; i < 40; i++) begin
         if (i == 2) op(1'b0, 1'b1, 16'h0002, 16'h0);
         else op(1'b0, 1'b0, 16'h0, 16'h0);
         s[i] = tx;
         if (i == 2) st = rd;
      end
      check("status_in_frame", st, 16'h0006);
      bad = 0;
      for (int i = 0; i < 40; i++) if (s[i] !== fr[i / 4]) bad++;
      check("frame_0x55_bad_cycles", 16'(bad), 16'h0);

      // back-to-back frames
      drain();
      op(1'b1, 1'b0, 16'h0001, 16'h00FF);
      prev = tx;
      for (int t = 0; t < 150; t++) begin
         if (t == 0) op(1'b1, 1'b0, 16'h0001, 16'h00FF);
         else op(1'b0, 1'b0, 16'h0, 16'h0);
         if (prev === 1'b1 && tx === 1'b0) falls.push_back(t);
         prev = tx;
      end
      check("start_bit_count", 16'(falls.size()), 16'h0002);
      if (falls.size() == 2) check("start_to_start", 16'(falls[1] - falls[0]), 16'd41);

      // overflow while busy
      drain();
      op(1'b1, 1'b0, 16'h0001, 16'h0011);
      op(1'b0, 1'b0, 16'h0, 16'h0);
      op(1'b0, 1'b0, 16'h0, 16'h0);
      op(1'b1, 1'b0, 16'h0001, 16'h0022);
      op(1'b1, 1'b0, 16'h0001, 16'h0033);
      op(1'b1, 1'b0, 16'h0001, 16'h0044);
      op(1'b1, 1'b0, 16'h0001, 16'h0055);
      op(1'b1, 1'b0, 16'h0001, 16'h0066);
      op(1'b0, 1'b1, 16'h0002, 16'h0);
      check("status_overflow", rd, 16'h040D);
      op(1'b1, 1'b0, 16'h0002, 16'h0008);
      op(1'b0, 1'b1, 16'h0002, 16'h0);
      check("status_ovf_cleared", rd, 16'h0405);
      n = 0;
      while (!(m_phase < 0 && m_q.size() == D) && n < 200) begin
         op(1'b0, 1'b0, 16'h0, 16'h0);
         n++;
      end
      check("idle_gap_timeout", 16'(n >= 200), 16'h0);
      op(1'b1, 1'b0, 16'h0001, 16'h0077);
      op(1'b0, 1'b1, 16'h0002, 16'h0);
      check("push_with_pop", rd, 16'h0405);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int sel;
         logic [15:0] a;
         sel = int'($urandom_range(0, 7));
         case (sel)
            0:          a = 16'h0000;
            1, 2, 3, 4: a = 16'h0001;
            5:          a = 16'h0002;
            6:          a = 16'($urandom);
            default:    a = 16'h0003;
         endcase
         op($urandom_range(0, 99) < ((i < 1500) ? 8 : 50), $urandom_range(0, 1) == 1,
            a, 16'($urandom));
      end

      // reset in the middle of DATA
      drain();
      op(1'b1, 1'b0, 16'h0001, 16'h00F0);
      n = 0;
      while (m_phase != C + 6 && n < 20) begin
         op(1'b0, 1'b0, 16'h0, 16'h0);
         n++;
      end
      check("mid_data_timeout", 16'(n >= 20), 16'h0);
      check("tx_before_reset", {15'b0, tx}, 16'h0000);
      #2 resetq = 1'b0;
      #1;
      check("async_reset_tx", {15'b0, tx}, 16'h0001);
      check("async_reset_leds", {8'h00, leds}, 16'h0000);
      check("async_reset_rd", rd, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      resetq = 1'b1;
      op(1'b0, 1'b1, 16'h0002, 16'h0);
      check("status_after_reset", rd, 16'h0002);
      repeat (60) op(1'b0, 1'b0, 16'h0, 16'h0);
      check("tx_idle_after_reset", {15'b0, tx}, 16'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
